// File: rtl/mantissa_mul_seq.sv
// Sequential shift-add significand multiplier: one partial product per clock,
// fixed W-cycle latency, full product plus normalized fraction/sticky for rounding.
module mantissa_mul_seq #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             init,
    input  logic             start,
    input  logic [W-1:0]     man1,
    input  logic [W-1:0]     man2,
    output logic             busy,
    output logic             out_en,
    output logic [2*W-1:0]   man_mul,
    output logic             inc_exp,
    output logic [W-2:0]     norm_man,
    output logic             sticky
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    count_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [2*W-1:0]   acc_r;
    logic [2*W-1:0]   man_mul_r;
    logic             busy_r;
    logic             out_en_r;

    logic             latch_s;
    logic             step_s;
    logic             finish_s;
    logic [2*W-1:0]   pp_s;
    logic [2*W-1:0]   acc_sum_s;

    // Partial product for the current multiplier bit and the running sum.
    always_comb begin
        pp_s = {(2*W){1'b0}};
        if (b_r[count_r]) begin
            pp_s = {{W{1'b0}}, a_r} << count_r;
        end else begin
            pp_s = {(2*W){1'b0}};
        end
        acc_sum_s = acc_r + pp_s;
    end

    // Next-state and control strobes.
    always_comb begin
        state_nx_s = state_r;
        latch_s    = 1'b0;
        step_s     = 1'b0;
        finish_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    latch_s    = 1'b1;
                    state_nx_s = ST_BUSY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                step_s = 1'b1;
                if (count_r == LAST_C) begin
                    finish_s   = 1'b1;
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, operand latches, accumulator and registered result/flags.
    always_ff @(posedge clk) begin
        if (init) begin
            state_r   <= ST_IDLE;
            count_r   <= {CW{1'b0}};
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            acc_r     <= {(2*W){1'b0}};
            man_mul_r <= {(2*W){1'b0}};
            busy_r    <= 1'b0;
            out_en_r  <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            busy_r   <= (state_nx_s != ST_IDLE);
            out_en_r <= finish_s;
            if (latch_s) begin
                a_r     <= man1;
                b_r     <= man2;
                acc_r   <= {(2*W){1'b0}};
                count_r <= {CW{1'b0}};
            end else if (step_s) begin
                acc_r <= acc_sum_s;
                if (finish_s) begin
                    // Result held here until the next completed multiply.
                    man_mul_r <= acc_sum_s;
                end else begin
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    // Normalization select: product in [2,4) shifts one extra place.
    always_comb begin
        inc_exp  = man_mul_r[2*W-1];
        norm_man = {(W-1){1'b0}};
        sticky   = 1'b0;
        if (man_mul_r[2*W-1]) begin
            norm_man = man_mul_r[2*W-2:W];
            sticky   = |man_mul_r[W-1:0];
        end else begin
            norm_man = man_mul_r[2*W-3:W-1];
            sticky   = |man_mul_r[W-2:0];
        end
    end

    assign busy    = busy_r;
    assign out_en  = out_en_r;
    assign man_mul = man_mul_r;

endmodule

// File: tb/tb_mantissa_mul_seq.sv
// Directed self-checking bench for mantissa_mul_seq (W=24).
module tb_mantissa_mul_seq;

    localparam int W = 24;

    logic             clk;
    logic             init;
    logic             start;
    logic [W-1:0]     man1;
    logic [W-1:0]     man2;
    logic             busy;
    logic             out_en;
    logic [2*W-1:0]   man_mul;
    logic             inc_exp;
    logic [W-2:0]     norm_man;
    logic             sticky;

    int checks   = 0;
    int failures = 0;

    mantissa_mul_seq #(.W(W)) dut (
        .clk      (clk),
        .init     (init),
        .start    (start),
        .man1     (man1),
        .man2     (man2),
        .busy     (busy),
        .out_en   (out_en),
        .man_mul  (man_mul),
        .inc_exp  (inc_exp),
        .norm_man (norm_man),
        .sticky   (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One multiply: start pulse, bounded wait for out_en, check latency and outputs.
    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [47:0] exp_p, input logic exp_inc,
                          input logic [22:0] exp_norm, input logic exp_sticky);
        int lat;
        logic seen;
        lat  = 0;
        seen = 1'b0;
        @(negedge clk);
        man1  = a;
        man2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        man1  = ~a;
        man2  = ~b;
        chk({tag, "_busy"}, {47'd0, busy}, 48'd1);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_en) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_out_en_seen"}, {47'd0, seen}, 48'd1);
        chk({tag, "_latency"}, 48'(lat), 48'd24);
        chk({tag, "_man_mul"}, man_mul, exp_p);
        chk({tag, "_inc_exp"}, {47'd0, inc_exp}, {47'd0, exp_inc});
        chk({tag, "_norm_man"}, {25'd0, norm_man}, {25'd0, exp_norm});
        chk({tag, "_sticky"}, {47'd0, sticky}, {47'd0, exp_sticky});
        @(posedge clk);
        #1;
        chk({tag, "_out_en_drop"}, {47'd0, out_en}, 48'd0);
        chk({tag, "_idle"}, {47'd0, busy}, 48'd0);
        chk({tag, "_hold"}, man_mul, exp_p);
    endtask

    initial begin
        int oe_cnt;
        int oe_j1;
        int oe_j2;
        int busy_cnt;
        int stray;
        logic [23:0] ra;
        logic [23:0] rb;
        logic [47:0] rp;

        init  = 1'b1;
        start = 1'b0;
        man1  = 24'd0;
        man2  = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_out_en", {47'd0, out_en}, 48'd0);
        chk("rst_man_mul", man_mul, 48'd0);
        chk("rst_norm", {25'd0, norm_man, inc_exp, sticky}, 48'd0);
        init = 1'b0;

        run_op("one_x_one", 24'h800000, 24'h800000, 48'h400000000000, 1'b0, 23'h000000, 1'b0);
        run_op("x1p5_x1p5", 24'hC00000, 24'hC00000, 48'h900000000000, 1'b1, 23'h100000, 1'b0);
        run_op("max_x_max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1, 23'h7FFFFE, 1'b1);
        run_op("lo_sticky", 24'hA00000, 24'h800001, 48'h500000A00000, 1'b0, 23'h200001, 1'b1);

        // Start held high; man1 changes during the first operation.
        @(negedge clk);
        man1     = 24'hC00000;
        man2     = 24'hC00000;
        start    = 1'b1;
        oe_cnt   = 0;
        oe_j1    = -1;
        oe_j2    = -1;
        busy_cnt = 0;
        for (int j = 0; j <= 51; j++) begin
            @(posedge clk);
            #1;
            if (j == 4) man1 = 24'h800000;
            if (j <= 25 && busy) busy_cnt++;
            if (out_en) begin
                oe_cnt++;
                if (oe_cnt == 1) begin
                    oe_j1 = j;
                    chk("bb_first_product", man_mul, 48'h900000000000);
                end else begin
                    oe_j2 = j;
                    chk("bb_second_product", man_mul, 48'h600000000000);
                end
            end
        end
        start = 1'b0;
        chk("bb_out_en_count", 48'(oe_cnt), 48'd2);
        chk("bb_first_at", 48'(oe_j1), 48'd24);
        chk("bb_period", 48'(oe_j2 - oe_j1), 48'd26);
        chk("bb_busy_cycles", 48'(busy_cnt), 48'd25);

        // Abort with init on BUSY cycle 10.
        @(negedge clk);
        man1  = 24'hFFFFFF;
        man2  = 24'hFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        chk("abort_busy", {47'd0, busy}, 48'd0);
        chk("abort_out_en", {47'd0, out_en}, 48'd0);
        chk("abort_man_mul", man_mul, 48'd0);
        chk("abort_derived", {25'd0, norm_man, inc_exp, sticky}, 48'd0);
        stray = 0;
        for (int j = 0; j < 30; j++) begin
            @(posedge clk);
            #1;
            if (out_en || busy) stray++;
        end
        chk("abort_no_pulse", 48'(stray), 48'd0);
        run_op("after_abort", 24'h800000, 24'hC00000, 48'h600000000000, 1'b0, 23'h400000, 1'b0);

        // Random normalized pairs against a reference product.
        for (int r = 0; r < 4; r++) begin
            ra = 24'($urandom) | 24'h800000;
            rb = 24'($urandom) | 24'h800000;
            rp = {24'd0, ra} * {24'd0, rb};
            if (rp[47]) begin
                run_op($sformatf("rand%0d", r), ra, rb, rp, 1'b1, rp[46:24], |rp[23:0]);
            end else begin
                run_op($sformatf("rand%0d", r), ra, rb, rp, 1'b0, rp[45:23], |rp[22:0]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mantissa_mul_seq.md
Name: mantissa_mul_seq

Overview:
Sequential shift-add significand multiplier for the single-precision FP multiply datapath. Sits directly upstream of the exponent adder stage and feeds it:
- inc_exp: product bit 47, which selects exp1+exp2-127+1 versus exp1+exp2-127.
- out_en: one-cycle pulse that tells the exponent stage to capture its result.
Also presents the normalized, truncated fraction and a sticky bit to the downstream rounding/pack stage.

Parameters:
W, 24, significand width including hidden bit; product width is 2W, counter width is clog2(W).

Ports:
clk  input  1  rising-edge clock
init  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
man1  input  W  significand A with hidden bit already prepended by upstream
man2  input  W  significand B with hidden bit already prepended by upstream
busy  output  1  high whenever state is not IDLE
out_en  output  1  one-cycle done pulse; drives exponent stage out_en
man_mul  output  2W  registered full product
inc_exp  output  1  man_mul[2W-1]; drives exponent stage inc_exp
norm_man  output  W-1  normalized fraction, hidden bit dropped
sticky  output  1  OR of all product bits below norm_man's LSB

Behaviour:
- Reset:
  - init is synchronous and active-high; it overrides start and any state.
  - On an init edge: state=IDLE, count=0, accumulator=0, man_mul=0, out_en=0, busy=0, inc_exp=0, norm_man=0, sticky=0.
  - init asserted mid-operation aborts the multiply; no out_en pulse follows.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 at edge E0: latch A=man1, B=man2, clear accumulator, count=0, go to BUSY.
  - start=0: stay in IDLE; man_mul and derived outputs hold their last result.
- BUSY, edges E1..EW (one partial product per edge, count = 0..W-1):
  - accumulator <= accumulator + (B[count] ? (A << count) : 0), computed in 2W bits.
  - The add never overflows, because the W x W product always fits in 2W bits.
  - When count==W-1 at that edge: accumulator takes its final value, man_mul <= final value, go to DONE.
  - Otherwise count increments.
- DONE:
  - out_en=1 for exactly one cycle, the cycle following edge EW, i.e. W cycles after the start edge (24 by default).
  - Next edge returns to IDLE; out_en drops.
- Fixed latency: there is no early exit for zero operands or zero multiplier bits.
- start while BUSY or DONE is ignored, not queued. A new start can be accepted no earlier than the first IDLE cycle after DONE. Back-to-back throughput is one result per W+2 cycles.
- man1 and man2 may change after E0 without affecting the result.
- Derived outputs are combinational from man_mul and stable whenever out_en=1:
  - inc_exp = man_mul[2W-1].
  - If inc_exp=1: norm_man = man_mul[2W-2:W], sticky = |man_mul[W-1:0].
  - If inc_exp=0: norm_man = man_mul[2W-3:W-1], sticky = |man_mul[W-2:0].
- Operand range: normalized significands, i.e. MSB set, product in [1,4). Denormal or zero operands still produce the exact integer product; normalization of such results is outside this block's contract.

Test Plan:
- 1.0 x 1.0: man1=man2=0x800000, start pulse -> out_en exactly 24 cycles after start edge; man_mul=0x400000000000; inc_exp=0; norm_man=0; sticky=0.
- 1.5 x 1.5: man1=man2=0xC00000 -> man_mul=0x900000000000; inc_exp=1; norm_man=0x100000; sticky=0.
- Maximum significands: man1=man2=0xFFFFFF -> man_mul=0xFFFFFE000001; inc_exp=1; norm_man=0x7FFFFE; sticky=1.
- Protocol: start held high continuously, and man1 changed on cycle 5 of BUSY:
  - Exactly one out_en per W+2 cycles.
  - Each result matches the operands latched at its own start edge.
  - busy is high for W+1 cycles per operation.
- Reset mid-operation: init on BUSY cycle 10 -> next cycle all outputs 0, state IDLE, no out_en pulse; a following start of 0x800000 x 0xC00000 yields man_mul=0x600000000000, inc_exp=0, norm_man=0x400000.
- Random normalized operand pairs checked against a reference 24x24 product: man_mul exact; inc_exp, norm_man and sticky consistent with the selection rules above.
